// File: rtl/ir_pkg.sv
// ir_pkg: shared types and constants for the IR command controller.
package ir_pkg;
    typedef enum logic [1:0] {NONE = 2'd0, PRESS = 2'd1, REPEAT = 2'd2, RELEASE = 2'd3} evt_kind_t;
    typedef enum logic {IDLE = 1'b0, HELD = 1'b1} ctrl_state_t;
    localparam int TMR_W       = 12;
    localparam int TIMEOUT_DEF = 2400;
endpackage

// File: rtl/ir_evt_fifo.sv
// ir_evt_fifo: 2-deep first-word-fall-through event buffer with a sticky drop flag.
module ir_evt_fifo (
    input  logic       slow_clk,
    input  logic       reset_n,
    input  logic       i_push,
    input  logic [9:0] i_din,
    input  logic       i_pop,
    output logic [9:0] o_dout,
    output logic       o_valid,
    output logic       o_drop
);
    logic [9:0] r_d0, r_d1;
    logic [1:0] r_cnt;
    logic       r_drop;
    logic       w_pop, w_push;
    logic [1:0] w_cnt_p;
    assign w_pop   = i_pop && (r_cnt != 2'd0);
    // a full buffer still takes a push when the head leaves in the same cycle
    assign w_push  = i_push && ((r_cnt != 2'd2) || w_pop);
    assign w_cnt_p = r_cnt - {1'b0, w_pop};
    always_ff @(posedge slow_clk) begin
        if (!reset_n) begin
            r_d0   <= '0;
            r_d1   <= '0;
            r_cnt  <= '0;
            r_drop <= 1'b0;
        end else begin
            r_cnt <= w_cnt_p + {1'b0, w_push};
            r_d0  <= (w_push && w_cnt_p == 2'd0) ? i_din : (w_pop ? r_d1 : r_d0);
            r_d1  <= (w_push && w_cnt_p == 2'd1) ? i_din : r_d1;
            if (i_push && !w_push) r_drop <= 1'b1;
        end
    end
    assign o_valid = r_cnt != 2'd0;
    assign o_dout  = o_valid ? r_d0 : '0;
    assign o_drop  = r_drop;
endmodule

// File: rtl/ir_cmd_ctrl.sv
// ir_cmd_ctrl: NEC command controller - address filter, press/hold/release tracking, event FIFO.
// Define IR_REPEAT_EN to generate REPEAT events from repeat frames.
module ir_cmd_ctrl
    import ir_pkg::*;
#(
    parameter logic [7:0] ADDR     = 8'h00,
    parameter int         TIMEOUT  = TIMEOUT_DEF,
    parameter int         REP_SKIP = 3,
    parameter int         REP_DIV  = 2
) (
    input  logic        slow_clk,
    input  logic        reset_n,
    input  logic [15:0] code,
    input  logic        code_valid,
    input  logic        repeat_pulse,
    output logic [1:0]  evt_kind,
    output logic [7:0]  evt_key,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic        dec_clr,
    output logic        held,
    output logic        ovf
);
    localparam logic [TMR_W-1:0] TO = TMR_W'(TIMEOUT);
    if (TIMEOUT < 1 || TIMEOUT > 4095 || REP_DIV < 1 || REP_SKIP < 0) begin : g_bad_param
        $error("ir_cmd_ctrl: illegal parameter value");
    end
    ctrl_state_t      r_state, w_state_n;
    logic [TMR_W-1:0] r_timer, w_timer_n;
    logic [7:0]       r_key, w_key_n;
    logic             w_match, w_push;
    evt_kind_t        w_kind;
    logic [9:0]       w_dout;
`ifdef IR_REPEAT_EN
    logic [7:0]       r_rep_cnt, w_rep_cnt_n, w_rep_inc;
`endif
    assign w_match = code_valid && (code[7:0] == ADDR);
    // the timer loads 1 on a frame so it equals TIMEOUT exactly TIMEOUT edges later
    always_comb begin
        w_state_n = r_state;
        w_timer_n = r_timer;
        w_key_n   = r_key;
        w_push    = 1'b0;
        w_kind    = NONE;
        dec_clr   = 1'b0;
`ifdef IR_REPEAT_EN
        w_rep_inc   = r_rep_cnt + {7'd0, ~&r_rep_cnt};
        w_rep_cnt_n = r_rep_cnt;
`endif
        if (w_match) begin
            w_state_n = HELD;
            w_timer_n = TMR_W'(1);
            w_key_n   = code[15:8];
            w_push    = 1'b1;
            w_kind    = PRESS;
`ifdef IR_REPEAT_EN
            w_rep_cnt_n = '0;
`endif
        end else if (r_state == HELD) begin
            if (repeat_pulse) begin
                w_timer_n = TMR_W'(1);
`ifdef IR_REPEAT_EN
                w_rep_cnt_n = w_rep_inc;
                if (int'(w_rep_inc) > REP_SKIP && (int'(w_rep_inc) - REP_SKIP - 1) % REP_DIV == 0) begin
                    w_push = 1'b1;
                    w_kind = REPEAT;
                end
`endif
            end else if (r_timer == TO) begin
                w_state_n = IDLE;
                w_timer_n = '0;
                w_push    = 1'b1;
                w_kind    = RELEASE;
                dec_clr   = 1'b1;
            end else begin
                w_timer_n = r_timer + {{(TMR_W-1){1'b0}}, ~&r_timer};
            end
        end
    end
    always_ff @(posedge slow_clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_key   <= '0;
`ifdef IR_REPEAT_EN
            r_rep_cnt <= '0;
`endif
        end else begin
            r_state <= w_state_n;
            r_timer <= w_timer_n;
            r_key   <= w_key_n;
`ifdef IR_REPEAT_EN
            r_rep_cnt <= w_rep_cnt_n;
`endif
        end
    end
    ir_evt_fifo u_fifo (
        .slow_clk (slow_clk),
        .reset_n  (reset_n),
        .i_push   (w_push),
        .i_din    ({w_kind, w_key_n}),
        .i_pop    (evt_valid && evt_ready),
        .o_dout   (w_dout),
        .o_valid  (evt_valid),
        .o_drop   (ovf)
    );
    assign evt_kind = w_dout[9:8];
    assign evt_key  = w_dout[7:0];
    assign held     = r_state == HELD;
endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// tb_ir_cmd_ctrl: scoreboard bench for ir_cmd_ctrl; REPEAT expectations follow IR_REPEAT_EN.
module tb_ir_cmd_ctrl;
    logic        slow_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] code = '0;
    logic        code_valid = 1'b0;
    logic        repeat_pulse = 1'b0;
    logic        evt_ready = 1'b0;
    logic [1:0]  evt_kind;
    logic [7:0]  evt_key;
    logic        evt_valid, dec_clr, held, ovf;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_rep = 0;
    int          n_pop = 0;
    int          pops_at_rst;
    logic [9:0]  sb[$];
`ifdef IR_REPEAT_EN
    localparam int EXP_REP = 3;
`else
    localparam int EXP_REP = 0;
`endif

    always #5 slow_clk = ~slow_clk;

    ir_cmd_ctrl dut (
        .slow_clk     (slow_clk),
        .reset_n      (reset_n),
        .code         (code),
        .code_valid   (code_valid),
        .repeat_pulse (repeat_pulse),
        .evt_kind     (evt_kind),
        .evt_key      (evt_key),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .dec_clr      (dec_clr),
        .held         (held),
        .ovf          (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge slow_clk);
            #1;
        end
    endtask

    task automatic frame(input logic [15:0] c);
        code = c;
        code_valid = 1'b1;
        tick(1);
        code_valid = 1'b0;
    endtask

    // transfers happen at the next rising edge; sample mid-cycle
    always @(negedge slow_clk) begin
        if (reset_n && evt_valid && evt_ready) begin
            n_pop++;
            if (evt_kind == 2'd2) n_rep++;
            if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
            else check("evt", {22'd0, evt_kind, evt_key}, {22'd0, sb.pop_front()});
        end
    end

    initial begin
        tick(2);
        check("rst_valid", evt_valid, 0);
        check("rst_kind", evt_kind, 0);
        check("rst_key", evt_key, 0);
        check("rst_held", held, 0);
        check("rst_dec_clr", dec_clr, 0);
        check("rst_ovf", ovf, 0);
        reset_n = 1'b1;
        evt_ready = 1'b1;
        tick(1);

        sb.push_back(10'h145);
        frame(16'h4500);
        check("press_valid", evt_valid, 1);
        check("press_held", held, 1);
        tick(2398);
        check("to_early_dec_clr", dec_clr, 0);
        check("to_early_held", held, 1);
        tick(1);
        check("to_dec_clr", dec_clr, 1);
        sb.push_back(10'h345);
        tick(1);
        check("rel_valid", evt_valid, 1);
        check("rel_kind", evt_kind, 3);
        check("rel_dec_clr_1cyc", dec_clr, 0);
        check("rel_held", held, 0);
        tick(3);
        frame(16'h4511);
        check("mismatch_held", held, 0);
        check("mismatch_valid", evt_valid, 0);

        tick(5);
        sb.push_back(10'h145);
        frame(16'h4500);
        for (int i = 1; i <= 8; i++) begin
            tick(1759);
`ifdef IR_REPEAT_EN
            if (i >= 4 && i % 2 == 0) sb.push_back(10'h245);
`endif
            repeat_pulse = 1'b1;
            tick(1);
            repeat_pulse = 1'b0;
            check("rep_held", held, 1);
        end
        tick(2398);
        check("rep_to_early_held", held, 1);
        check("rep_to_early_dec_clr", dec_clr, 0);
        tick(1);
        check("rep_to_dec_clr", dec_clr, 1);
        sb.push_back(10'h345);
        tick(2);
        check("rep_rel_held", held, 0);
        check("rep_count", n_rep, EXP_REP);

        tick(3);
        evt_ready = 1'b0;
        sb.push_back(10'h145);
        frame(16'h4500);
        sb.push_back(10'h146);
        frame(16'h4600);
        frame(16'h4700);
        check("bp_ovf", ovf, 1);
        check("bp_head", {evt_kind, evt_key}, 10'h145);
        tick(5);
        check("bp_hold_stable", {evt_kind, evt_key}, 10'h145);
        check("bp_valid", evt_valid, 1);
        evt_ready = 1'b1;
        tick(3);
        check("bp_drained", sb.size(), 0);
        check("bp_ovf_sticky", ovf, 1);
        check("bp_empty", evt_valid, 0);

        code = 16'h4500;
        code_valid = 1'b1;
        repeat_pulse = 1'b1;
        sb.push_back(10'h145);
        tick(1);
        code_valid = 1'b0;
        repeat_pulse = 1'b0;
        check("coll_kind", evt_kind, 1);
        tick(2398);
        check("coll_to_early", dec_clr, 0);
        tick(1);
        check("coll_to_dec_clr", dec_clr, 1);
        code = 16'h4600;
        code_valid = 1'b1;
        #1;
        check("coll_to_dec_clr_gated", dec_clr, 0);
        sb.push_back(10'h146);
        tick(1);
        code_valid = 1'b0;
        check("coll_to_held", held, 1);
        check("coll_to_evt", {evt_kind, evt_key}, 10'h146);
        tick(3);

        evt_ready = 1'b0;
        frame(16'h4700);
        frame(16'h4800);
        check("rh_full_valid", evt_valid, 1);
        pops_at_rst = n_pop;
        reset_n = 1'b0;
        tick(1);
        check("rh_valid", evt_valid, 0);
        check("rh_kind", evt_kind, 0);
        check("rh_key", evt_key, 0);
        check("rh_held", held, 0);
        check("rh_dec_clr", dec_clr, 0);
        check("rh_ovf", ovf, 0);
        reset_n = 1'b1;
        evt_ready = 1'b1;
        tick(2600);
        check("rh_no_release", n_pop, pops_at_rst);
        check("rh_idle", held, 0);
        check("sb_left", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
